// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Groups the CPU data-memory request/response signals.
//   req        : transaction request (CPU -> memory)
//   write_enab : 1 = store, 0 = load
//   data_addr  : byte address
//   write_data : store data
//   read_data  : load data, valid while ready is high
//   ready      : one-cycle transaction-complete pulse
// Modports: master = CPU side, slave = memory responder side.
interface dmem_responder_if;
    logic        req;
    logic        write_enab;
    logic [31:0] data_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output req, write_enab, data_addr, write_data,
        input  read_data, ready
    );

    modport slave (
        input  req, write_enab, data_addr, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
// Wait-stated data memory model for a CPU test harness, with a pass/fail
// mailbox that reports the outcome of a test program.
// Ports:
//   clk            : single clock, all state updates on its rising edge
//   reset          : asynchronous, active-high
//   bus            : dmem_responder_if.slave (req/write_enab/data_addr/
//                    write_data in, read_data/ready out)
//   done           : sticky, a status-deciding write has committed
//   pass           : sticky, meaningful only while done is high
//   err_misaligned : sticky, a request with data_addr[1:0] != 0 was accepted
//   err_range      : sticky, an aligned request beyond the storage was accepted
module dmem_responder #(
    parameter int          DEPTH_WORDS  = 64,
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] PASS_ADDR    = 32'd84,
    parameter logic [31:0] PASS_DATA    = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR = 32'd80
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic              done,
    output logic              pass,
    output logic              err_misaligned,
    output logic              err_range
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        lat_aligned;
    logic        lat_in_range;
    logic        commit;
    logic [31:0] resp_addr;
    logic [31:0] resp_word;

    // Decode of the latched transaction. A write commits on the edge that
    // ends RESP, and only when it targets a real storage word.
    always_comb begin
        lat_aligned  = (lat_addr[1:0] == 2'b00);
        lat_in_range = (lat_addr[31:2] < DEPTH_LIMIT);
        commit       = (state == RESP) && lat_we && lat_aligned && lat_in_range;
    end

    // Load value for the transaction about to enter RESP. With zero wait
    // states RESP follows IDLE directly, so the live bus address is used;
    // otherwise the latched one. Bad addresses read as zero.
    always_comb begin
        resp_addr = (state == IDLE) ? bus.data_addr : lat_addr;
        resp_word = 32'd0;
        if ((resp_addr[1:0] == 2'b00) && (resp_addr[31:2] < DEPTH_LIMIT))
            resp_word = mem[resp_addr[IDX_W+1:2]];
    end

    // Storage is deliberately not reset; a reset during RESP moves the FSM
    // out of RESP asynchronously, which suppresses the commit.
    always_ff @(posedge clk) begin
        if (commit)
            mem[lat_addr[IDX_W+1:2]] <= lat_wdata;
    end

    // Transaction FSM with registered ready/read_data plus the sticky
    // status and error flags, all updated on the edge that ends RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= 4'd0;
            lat_we         <= 1'b0;
            lat_addr       <= 32'd0;
            lat_wdata      <= 32'd0;
            bus.ready      <= 1'b0;
            bus.read_data  <= 32'd0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_misaligned <= 1'b0;
            err_range      <= 1'b0;
        end else begin
            bus.ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        lat_we    <= bus.write_enab;
                        lat_addr  <= bus.data_addr;
                        lat_wdata <= bus.write_data;
                        if (WAIT_STATES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state     <= RESP;
                            bus.ready <= 1'b1;
                            if (!bus.write_enab)
                                bus.read_data <= resp_word;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= RESP;
                        bus.ready <= 1'b1;
                        if (!lat_we)
                            bus.read_data <= resp_word;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (!lat_aligned)
                        err_misaligned <= 1'b1;
                    else if (!lat_in_range)
                        err_range <= 1'b1;
                    // Only the first deciding write sets the verdict; the
                    // scratch word lets programs store without ending the test.
                    if (commit && !done && (lat_addr != SCRATCH_ADDR)) begin
                        done <= 1'b1;
                        pass <= (lat_addr == PASS_ADDR) && (lat_wdata == PASS_DATA);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed self-checking bench for dmem_responder with default parameters
// (64 words, one wait state, mailbox at 84, scratch at 80).
module tb_dmem_responder;

    localparam int WAIT_STATES = 1;
    localparam int EXP_LAT     = 1 + WAIT_STATES;

    logic clk;
    logic reset;
    logic done, pass, err_misaligned, err_range;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (64),
        .WAIT_STATES (WAIT_STATES),
        .PASS_ADDR   (32'd84),
        .PASS_DATA   (32'd7),
        .SCRATCH_ADDR(32'd80)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .done          (done),
        .pass          (pass),
        .err_misaligned(err_misaligned),
        .err_range     (err_range)
    );

    int checks = 0;
    int errors = 0;

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_done;
        logic        exp_pass;
        logic        exp_mis;
        logic        exp_rng;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete transaction: present the request before an edge, drop req
    // after acceptance, wait (bounded) for ready, then step past RESP so the
    // sticky flags reflect the transaction. lat counts edges from the
    // accepting edge (inclusive) to the edge that raised ready.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output logic [31:0] rdata);
        bit got;
        got   = 1'b0;
        lat   = -1;
        rdata = 32'hdead_beef;
        @(negedge clk);
        bus.req        = 1'b1;
        bus.write_enab = we;
        bus.data_addr  = addr;
        bus.write_data = wdata;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            bus.req = 1'b0;
            if (bus.ready) begin
                lat   = c;
                rdata = bus.read_data;
                got   = 1'b1;
                break;
            end
        end
        if (!got)
            checkOutput("ready timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("ready one cycle", {31'd0, bus.ready}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        int          ready_cyc [4];
        int          n;
        int          extra;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_data [4];

        vecs[0] = '{1'b1, 32'd80,  32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'd80,  32'd0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'd81,  32'd3, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'd80,  32'd0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'd256, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 32'd256, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 32'd84,  32'd7, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 32'd60,  32'd9, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 32'd60,  32'd0, 1'b1, 32'd9, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 32'd84,  32'd0, 1'b1, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1};

        bus.req        = 1'b0;
        bus.write_enab = 1'b0;
        bus.data_addr  = 32'd0;
        bus.write_data = 32'd0;
        reset          = 1'b1;

        #2;
        checkOutput("reset ready", {31'd0, bus.ready}, 32'd0);
        checkOutput("reset read_data", bus.read_data, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset pass", {31'd0, pass}, 32'd0);
        checkOutput("reset err_misaligned", {31'd0, err_misaligned}, 32'd0);
        checkOutput("reset err_range", {31'd0, err_range}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table of single transactions from a clean reset.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
            checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(EXP_LAT));
            if (vecs[i].chk_rd)
                checkOutput($sformatf("v%0d read_data", i), rd, vecs[i].exp_rd);
            checkOutput($sformatf("v%0d done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
            checkOutput($sformatf("v%0d pass", i), {31'd0, pass}, {31'd0, vecs[i].exp_pass});
            checkOutput($sformatf("v%0d err_misaligned", i), {31'd0, err_misaligned}, {31'd0, vecs[i].exp_mis});
            checkOutput($sformatf("v%0d err_range", i), {31'd0, err_range}, {31'd0, vecs[i].exp_rng});
        end

        // Failing verdict is frozen; storage keeps taking writes.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst2 done", {31'd0, done}, 32'd0);
        checkOutput("rst2 err_range", {31'd0, err_range}, 32'd0);
        applyStimulus(1'b1, 32'd84, 32'd6, lat, rd);
        checkOutput("fail done", {31'd0, done}, 32'd1);
        checkOutput("fail pass", {31'd0, pass}, 32'd0);
        applyStimulus(1'b1, 32'd84, 32'd7, lat, rd);
        checkOutput("frozen done", {31'd0, done}, 32'd1);
        checkOutput("frozen pass", {31'd0, pass}, 32'd0);
        applyStimulus(1'b1, 32'd84, 32'd2, lat, rd);
        applyStimulus(1'b0, 32'd84, 32'd0, lat, rd);
        checkOutput("word21 after frozen", rd, 32'd2);

        // Reset in the middle of WAIT aborts a passing mailbox write.
        @(negedge clk);
        bus.req        = 1'b1;
        bus.write_enab = 1'b1;
        bus.data_addr  = 32'd84;
        bus.write_data = 32'd7;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort ready", {31'd0, bus.ready}, 32'd0);
        checkOutput("abort read_data", bus.read_data, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort pass", {31'd0, pass}, 32'd0);
        checkOutput("abort err_misaligned", {31'd0, err_misaligned}, 32'd0);
        checkOutput("abort err_range", {31'd0, err_range}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort done after release", {31'd0, done}, 32'd0);
        checkOutput("abort no ready", {31'd0, bus.ready}, 32'd0);
        applyStimulus(1'b0, 32'd84, 32'd0, lat, rd);
        checkOutput("abort latency", 32'(lat), 32'(EXP_LAT));
        checkOutput("abort word21", rd, 32'd2);
        checkOutput("abort done after read", {31'd0, done}, 32'd0);

        // req held high with alternating writes: ready every 2+WAIT_STATES cycles.
        b2b_addr = '{32'd40, 32'd44, 32'd40, 32'd44};
        b2b_data = '{32'h11, 32'h22, 32'h33, 32'h44};
        n = 0;
        @(negedge clk);
        bus.req        = 1'b1;
        bus.write_enab = 1'b1;
        bus.data_addr  = b2b_addr[0];
        bus.write_data = b2b_data[0];
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.ready) begin
                ready_cyc[n] = c;
                n++;
                if (n == 4) begin
                    bus.req = 1'b0;
                end else begin
                    bus.data_addr  = b2b_addr[n];
                    bus.write_data = b2b_data[n];
                end
            end
        end
        bus.req = 1'b0;
        checkOutput("b2b pulse count", 32'(n), 32'd4);
        if (n == 4) begin
            checkOutput("b2b first latency", 32'(ready_cyc[0]), 32'(EXP_LAT));
            for (int k = 1; k < 4; k++)
                checkOutput($sformatf("b2b gap %0d", k), 32'(ready_cyc[k] - ready_cyc[k-1]),
                            32'(2 + WAIT_STATES));
        end
        extra = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.ready) extra++;
        end
        checkOutput("b2b no extra ready", 32'(extra), 32'd0);
        checkOutput("b2b done", {31'd0, done}, 32'd1);
        checkOutput("b2b pass", {31'd0, pass}, 32'd0);
        applyStimulus(1'b0, 32'd40, 32'd0, lat, rd);
        checkOutput("b2b word10", rd, 32'h33);
        applyStimulus(1'b0, 32'd44, 32'd0, lat, rd);
        checkOutput("b2b word11", rd, 32'h44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 32-bit words of backing storage.
REQ-002 Parameter WAIT_STATES, default 1: number of wait cycles inserted per transaction (0..15).
REQ-003 Parameter PASS_ADDR, default 84: byte address of the pass/fail mailbox.
REQ-004 Parameter PASS_DATA, default 7: data value that signals pass when written to PASS_ADDR.
REQ-005 Parameter SCRATCH_ADDR, default 80: byte address whose writes never change pass/fail status.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  reset, asynchronous and active-high.
REQ-008 req  input  1  CPU transaction request; sampled only in IDLE.
REQ-009 write_enab  input  1  1 = write, 0 = read; sampled with req.
REQ-010 data_addr  input  32  byte address; sampled with req.
REQ-011 write_data  input  32  store data; sampled with req.
REQ-012 read_data  output  32  load data; valid while ready=1; holds its value until the next ready.
REQ-013 ready  output  1  one-cycle transaction-complete pulse.
REQ-014 done  output  1  sticky; a status-deciding write has committed.
REQ-015 pass  output  1  sticky; meaningful only while done=1.
REQ-016 err_misaligned  output  1  sticky; a request with data_addr[1:0] != 0 was accepted.
REQ-017 err_range  output  1  sticky; an aligned request with word index >= DEPTH_WORDS was accepted.

Function
REQ-018 FSM states: IDLE, WAIT, RESP.
REQ-019 IDLE with req=1: latch write_enab, data_addr and write_data at that edge; go to WAIT if WAIT_STATES>0, else to RESP.
REQ-020 WAIT: count down WAIT_STATES cycles, then go to RESP; req, data_addr, write_enab and write_data are ignored while in WAIT.
REQ-021 RESP: ready=1 for exactly one cycle, then return to IDLE; ready rises 1+WAIT_STATES cycles after the accepting edge.
REQ-022 req held continuously high: the next transaction is accepted in the IDLE cycle following RESP (throughput of one transaction per 2+WAIT_STATES cycles).
REQ-023 Write commit: storage[data_addr[31:2]] is updated on the edge that ends RESP, only if the address is aligned and in range.
REQ-024 Read: read_data equals storage[data_addr[31:2]] during RESP, using the latched address.
REQ-025 Read to a misaligned or out-of-range address: read_data = 0; the matching error flag is set.
REQ-026 Misaligned or out-of-range write: no storage update, no effect on done/pass; the matching error flag is set.
REQ-027 Error flags set on the edge that ends RESP and stay set until reset.
REQ-028 Status rule, applies to a committed write while done=0:
  - address == SCRATCH_ADDR: no status change;
  - address == PASS_ADDR and data == PASS_DATA: done=1, pass=1;
  - any other address, or PASS_ADDR with other data: done=1, pass=0.
REQ-029 Once done=1, done and pass are frozen until reset; storage writes continue normally.
REQ-030 Reads never affect done or pass.

Reset
REQ-031 reset=1 forces, asynchronously: state=IDLE, ready=0, read_data=0, done=0, pass=0, err_misaligned=0, err_range=0, and the wait counter to 0.
REQ-032 Reset during WAIT or RESP aborts the transaction; no storage write and no status or flag update occur.
REQ-033 Storage contents are not reset; reading a word that was never written returns an undefined value.
REQ-034 The first transaction can be accepted on the first rising edge after reset deasserts.

Verification
REQ-035 WAIT_STATES=1: write 80<-5, then read 80 -> each ready pulse occurs 2 cycles after acceptance; read_data=5; done=0.
REQ-036 Write 84<-7 -> done=1, pass=1; a subsequent write 60<-9 leaves done=1, pass=1 and a read of 60 returns 9.
REQ-037 After reset, write 84<-6 -> done=1, pass=0; a later write 84<-7 leaves pass=0.
REQ-038 Write 81<-3 -> err_misaligned=1, word 20 unchanged, done=0; write 256<-1 -> err_range=1; a read of 256 returns 0.
REQ-039 req held high with alternating writes -> back-to-back ready pulses exactly 3 cycles apart; no request lost or duplicated.
REQ-040 Assert reset during WAIT of write 84<-7 -> all outputs 0 immediately; word 21 unchanged; done stays 0 after reset is released.
